// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array edge feeders.
package systolic_pkg;

  localparam int SYSTOLIC_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    LOAD,
    LOADED,
    FEED,
    FLUSH
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one skewed lane (data and valid packed together).
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_row_feeder.sv
// West-edge A-operand feeder: buffers a tile, then emits it with per-row diagonal skew.
// SYSTOLIC_FEEDER_DBUF_EN selects two ping-pong tile banks instead of one.
//   state  | meaning
//   LOAD   | idle, accepting vectors, no tile ready
//   LOADED | idle, oldest bank holds a complete tile awaiting start
//   FEED   | lane 0 reading vectors out of the fed bank
//   FLUSH  | lane 0 idle, skewed lanes draining
module systolic_row_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = SYSTOLIC_DATA_WIDTH,
  parameter int ROWS       = 4,
  parameter int K_DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_last,
  input  logic                       start,
  output logic [ROWS*DATA_WIDTH-1:0] a_edge,
  output logic [ROWS-1:0]            a_edge_valid,
  output logic                       tile_loaded,
  output logic                       busy,
  output logic                       tile_done,
  output logic                       err_len
);

  localparam int LW = ROWS * DATA_WIDTH;
  localparam int CW = $clog2(K_DEPTH + 1);
  localparam int AW = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam int FW = $clog2(ROWS + 1);
`ifdef SYSTOLIC_FEEDER_DBUF_EN
  localparam logic BANK_STEP = 1'b1;
`else
  localparam logic BANK_STEP = 1'b0;
`endif

  feeder_state_e state_q, state_d;
  logic [LW-1:0] mem_q [2][K_DEPTH];
  logic [LW-1:0] mem_d [2][K_DEPTH];
  logic [CW-1:0] len_q [2];
  logic [CW-1:0] len_d [2];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          feed_bank_q, feed_bank_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] feed_cnt_q, feed_cnt_d;
  logic [CW-1:0] feed_len_q, feed_len_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [LW-1:0] stage_data_q, stage_data_d;
  logic [ROWS-1:0] stage_vld_q, stage_vld_d;
  logic          in_ready_q, in_ready_d;
  logic          tile_loaded_q, tile_loaded_d;
  logic          busy_q, busy_d;
  logic          tile_done_q, tile_done_d;
  logic          err_len_q, err_len_d;
  logic          beat;
  logic          close;

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    len_d         = len_q;
    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    feed_bank_d   = feed_bank_q;
    wr_cnt_d      = wr_cnt_q;
    feed_cnt_d    = feed_cnt_q;
    feed_len_d    = feed_len_q;
    flush_cnt_d   = flush_cnt_q;
    stage_data_d  = '0;
    stage_vld_d   = '0;
    tile_done_d   = 1'b0;
    err_len_d     = err_len_q;

    beat  = in_valid & in_ready_q;
    close = beat & (in_last | (wr_cnt_q == CW'(K_DEPTH - 1)));

    if (beat) begin
      mem_d[wr_bank_q][wr_cnt_q[AW-1:0]] = in_data;
      if (close) begin
        full_d[wr_bank_q] = 1'b1;
        len_d[wr_bank_q]  = wr_cnt_q + CW'(1);
        wr_cnt_d          = '0;
        wr_bank_d         = wr_bank_q ^ BANK_STEP;
        err_len_d         = err_len_q | ~in_last;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end

    case (state_q)
      LOAD, LOADED: begin
        if (start && tile_loaded_q) begin
          state_d           = FEED;
          feed_bank_d       = rd_bank_q;
          feed_len_d        = len_q[rd_bank_q];
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = rd_bank_q ^ BANK_STEP;
          stage_data_d      = mem_q[rd_bank_q][0];
          stage_vld_d       = '1;
          feed_cnt_d        = CW'(1);
        end
      end
      FEED: begin
        if (feed_cnt_q < feed_len_q) begin
          stage_data_d = mem_q[feed_bank_q][feed_cnt_q[AW-1:0]];
          stage_vld_d  = '1;
          feed_cnt_d   = feed_cnt_q + CW'(1);
        end else if (ROWS == 1) begin
          state_d     = LOAD;
          tile_done_d = 1'b1;
        end else begin
          state_d     = FLUSH;
          flush_cnt_d = FW'(1);
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FW'(ROWS - 1)) begin
          state_d     = LOAD;
          tile_done_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      default: state_d = LOAD;
    endcase

    // An idle feeder advertises LOADED once the oldest bank is complete.
    if (state_q == LOAD && state_d == LOAD && full_d[rd_bank_d]) begin
      state_d = LOADED;
    end

    tile_loaded_d = full_d[rd_bank_d];
    busy_d        = (state_d == FEED) || (state_d == FLUSH);
`ifdef SYSTOLIC_FEEDER_DBUF_EN
    in_ready_d = ~full_d[wr_bank_d] & ~((state_d == FEED) & (feed_bank_d == wr_bank_d));
`else
    in_ready_d = (state_d == LOAD);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LOAD;
      for (int b = 0; b < 2; b++) begin
        len_q[b] <= '0;
        for (int k = 0; k < K_DEPTH; k++) begin
          mem_q[b][k] <= '0;
        end
      end
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      feed_bank_q   <= 1'b0;
      wr_cnt_q      <= '0;
      feed_cnt_q    <= '0;
      feed_len_q    <= '0;
      flush_cnt_q   <= '0;
      stage_data_q  <= '0;
      stage_vld_q   <= '0;
      in_ready_q    <= 1'b1;
      tile_loaded_q <= 1'b0;
      busy_q        <= 1'b0;
      tile_done_q   <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      len_q         <= len_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      feed_bank_q   <= feed_bank_d;
      wr_cnt_q      <= wr_cnt_d;
      feed_cnt_q    <= feed_cnt_d;
      feed_len_q    <= feed_len_d;
      flush_cnt_q   <= flush_cnt_d;
      stage_data_q  <= stage_data_d;
      stage_vld_q   <= stage_vld_d;
      in_ready_q    <= in_ready_d;
      tile_loaded_q <= tile_loaded_d;
      busy_q        <= busy_d;
      tile_done_q   <= tile_done_d;
      err_len_q     <= err_len_d;
    end
  end

  assign a_edge[DATA_WIDTH-1:0] = stage_data_q[DATA_WIDTH-1:0];
  assign a_edge_valid[0]        = stage_vld_q[0];

  for (genvar r = 1; r < ROWS; r++) begin : g_skew
    logic [DATA_WIDTH:0] skew_out;

    skew_delay_line #(
      .DEPTH(r),
      .WIDTH(DATA_WIDTH + 1)
    ) u_skew (
      .clk  (clk),
      .rst  (rst),
      .d_in ({stage_vld_q[r], stage_data_q[r*DATA_WIDTH +: DATA_WIDTH]}),
      .d_out(skew_out)
    );

    assign a_edge[r*DATA_WIDTH +: DATA_WIDTH] = skew_out[DATA_WIDTH-1:0];
    assign a_edge_valid[r]                    = skew_out[DATA_WIDTH];
  end

  assign in_ready    = in_ready_q;
  assign tile_loaded = tile_loaded_q;
  assign busy        = busy_q;
  assign tile_done   = tile_done_q;
  assign err_len     = err_len_q;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Self-checking bench for systolic_row_feeder: table-driven tiles, random tiles, reset and backpressure sequences.
module tb_systolic_row_feeder;

  localparam int DW   = 16;
  localparam int ROWS = 4;
  localparam int KD   = 8;
  localparam int LW   = ROWS * DW;
`ifdef SYSTOLIC_FEEDER_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_data;
  logic          in_last;
  logic          start;
  logic [LW-1:0] a_edge;
  logic [ROWS-1:0] a_edge_valid;
  logic          tile_loaded;
  logic          busy;
  logic          tile_done;
  logic          err_len;

  int n_checks = 0;
  int n_err    = 0;

  logic [LW-1:0] tile_q [$];
  logic [LW-1:0] nxt_q [$];

  typedef struct {
    int   len;
    logic last;
    logic exp_err;
  } tile_vec_t;

  tile_vec_t tbl [6];

  systolic_row_feeder #(
    .DATA_WIDTH(DW),
    .ROWS      (ROWS),
    .K_DEPTH   (KD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .start       (start),
    .a_edge      (a_edge),
    .a_edge_valid(a_edge_valid),
    .tile_loaded (tile_loaded),
    .busy        (busy),
    .tile_done   (tile_done),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] pat_vec(input int k);
    logic [LW-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      v[r*DW +: DW] = DW'((k << 4) | r);
    end
    return v;
  endfunction

  task automatic load_tile(input int n, input logic last, input logic gaps, input logic pattern);
    logic [LW-1:0] v;
    int w;
    tile_q.delete();
    for (int k = 0; k < n; k++) begin
      v = pattern ? pat_vec(k) : {$urandom, $urandom};
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = v;
      in_last  = last && (k == n - 1);
      w = 0;
      while (!in_ready && w < 50) begin
        step();
        w++;
      end
      chk("ready_wait", 64'(w < 50), 64'd1);
      step();
      tile_q.push_back(v);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expected outputs follow from the skew rule: lane r shows vector c-1-r at cycle c.
  task automatic run_feed(input int nb);
    int len;
    int bi;
    int j;
    logic acc;
    logic [LW-1:0] ed;
    logic [ROWS-1:0] ev;
    len = tile_q.size();
    bi  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= len + ROWS; c++) begin
      ed = '0;
      ev = '0;
      for (int r = 0; r < ROWS; r++) begin
        j = c - 1 - r;
        if (j >= 0 && j < len) begin
          ev[r]          = 1'b1;
          ed[r*DW +: DW] = tile_q[j][r*DW +: DW];
        end
      end
      chk($sformatf("a_edge c%0d", c), a_edge, ed);
      chk($sformatf("a_edge_valid c%0d", c), 64'(a_edge_valid), 64'(ev));
      chk($sformatf("busy_done c%0d", c), {busy, tile_done}, {c < len + ROWS, c == len + ROWS});
`ifndef SYSTOLIC_FEEDER_DBUF_EN
      chk($sformatf("in_ready c%0d", c), 64'(in_ready), 64'(c == len + ROWS));
`endif
      if (c < len + ROWS) begin
        acc = 1'b0;
        if (bi < nb) begin
          in_valid = 1'b1;
          in_data  = nxt_q[bi];
          in_last  = (bi == nb - 1);
          acc      = in_ready;
        end else if (nb > 0) begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
        step();
        if (acc) bi++;
      end
    end
    if (nb > 0) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("bank_b_beats", 64'(bi), 64'(nb));
    end
  endtask

  initial begin
    logic exp_err;
    int   len;
    logic [LW-1:0] d9;

    tbl[0] = '{len: 3, last: 1'b1, exp_err: 1'b0};
    tbl[1] = '{len: 1, last: 1'b1, exp_err: 1'b0};
    tbl[2] = '{len: 8, last: 1'b1, exp_err: 1'b0};
    tbl[3] = '{len: 5, last: 1'b1, exp_err: 1'b0};
    tbl[4] = '{len: 8, last: 1'b0, exp_err: 1'b1};
    tbl[5] = '{len: 2, last: 1'b1, exp_err: 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();

    chk("reset_outputs", {a_edge_valid, busy, tile_done, tile_loaded, err_len}, '0);
    chk("reset_a_edge", a_edge, '0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Reference tile: 3 vectors closed by in_last, fixed pattern.
    load_tile(3, 1'b1, 1'b0, 1'b1);
    chk("t2_loaded", {tile_loaded, in_ready, err_len}, {1'b1, DBUF, 1'b0});
    run_feed(0);
    step();

    exp_err = 1'b0;
    for (int t = 0; t < 5; t++) begin
      len = $urandom_range(1, KD);
      load_tile(len, 1'b1, 1'b1, 1'b0);
      chk("rand_loaded", {tile_loaded, err_len}, {1'b1, exp_err});
      run_feed(0);
      step();
    end

    for (int i = 0; i < 6; i++) begin
      load_tile(tbl[i].len, tbl[i].last, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_loaded", i), {tile_loaded, in_ready, err_len}, {1'b1, DBUF, tbl[i].exp_err});
      run_feed(0);
      step();
    end

`ifndef SYSTOLIC_FEEDER_DBUF_EN
    // Full tile without in_last, then a ninth vector held against backpressure.
    load_tile(8, 1'b0, 1'b0, 1'b1);
    chk("t4_loaded", {tile_loaded, err_len}, 2'b11);
    d9 = {$urandom, $urandom};
    in_valid = 1'b1;
    in_data  = d9;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall", 64'(in_ready), 64'd0);
      step();
    end
    run_feed(0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t3_ninth_loaded", 64'(tile_loaded), 64'd1);
    tile_q.delete();
    tile_q.push_back(d9);
    run_feed(0);
    step();
`endif

    // Asynchronous reset in the middle of FEED.
    load_tile(3, 1'b1, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_pre_reset_valid", 64'(a_edge_valid), 64'h3);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_clear", {a_edge_valid, busy, tile_loaded, err_len, in_ready}, {{ROWS{1'b0}}, 4'b0001});
    chk("t5_async_a_edge", a_edge, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_quiet", {tile_done, busy, a_edge_valid, tile_loaded}, '0);
    end
    chk("t5_ready", 64'(in_ready), 64'd1);
    load_tile(2, 1'b1, 1'b1, 1'b0);
    chk("t5_recover_loaded", {tile_loaded, err_len}, 2'b10);
    run_feed(0);
    step();

`ifdef SYSTOLIC_FEEDER_DBUF_EN
    // Tile B loads while A feeds, then starts on A's tile_done cycle.
    load_tile(3, 1'b1, 1'b0, 1'b1);
    nxt_q.delete();
    for (int i = 0; i < 3; i++) nxt_q.push_back({$urandom, $urandom});
    run_feed(3);
    chk("t6_b_loaded", 64'(tile_loaded), 64'd1);
    tile_q = nxt_q;
    run_feed(0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
